ahb3lite_arb: RTL and testbench
===============================

Name: ahb3lite_arb

Overview:
- N-master to single-slave AHB3-lite bus arbiter.
- Lets several AHB masters, such as multiple test-vector masters, share one slave port. Non-owning masters are stalled via their private HREADY.
- Ownership moves only at transfer boundaries, so no address phase is ever dropped or duplicated.
- Round-robin by default.

Parameters:
NMASTER, 2, number of requesting masters (2..8)
DEFAULT_OWNER, 0, master that owns/parks the bus after reset

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
M_HADDR  in  NMASTER*32  per-master address, master m at [m*32+:32]
M_HWDATA  in  NMASTER*32  per-master write data
M_HWRITE  in  NMASTER  per-master write flag
M_HSIZE  in  NMASTER*3  per-master size
M_HBURST  in  NMASTER*3  per-master burst
M_HPROT  in  NMASTER*4  per-master protection
M_HTRANS  in  NMASTER*2  per-master transfer type
M_HRDATA  out  32  read data, broadcast to all masters
M_HRESP  out  NMASTER  per-master response
M_HREADY  out  NMASTER  per-master ready
HADDR, HWDATA  out  32  slave-side address, write data
HWRITE  out  1  slave-side write flag
HSIZE, HBURST  out  3  slave-side size, burst
HPROT  out  4  slave-side protection
HTRANS  out  2  slave-side transfer type
HRDATA  in  32  slave read data
HRESP  in  1  slave response
HREADY  in  1  slave ready
GRANT  out  NMASTER  one-hot address-phase owner

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RESET).
- Registers:
  - aowner: address-phase owner index.
  - downer: data-phase owner index.
  - dvalid: the data phase in flight is non-IDLE.
- Reset:
  - aowner = downer = DEFAULT_OWNER; dvalid = 0; GRANT = one-hot(DEFAULT_OWNER).
  - Reset mid-transfer aborts the transfer. Bus shows the DEFAULT_OWNER signals the cycle after reset deasserts.
- Request: req[m] = M_HTRANS[m] == NONSEQ.
- Address mux (combinational): HADDR/HWRITE/HSIZE/HBURST/HPROT/HTRANS = master aowner's signals. Zero latency.
- Data mux: HWDATA = M_HWDATA[downer]. M_HRDATA = HRDATA unconditionally.
- Per-master ready and response:
  - m == aowner: M_HREADY[m] = HREADY, M_HRESP[m] = HRESP.
  - m != aowner and req[m]: M_HREADY[m] = 0 (stalled; the master holds its address per protocol), M_HRESP[m] = 0.
  - m != aowner, not requesting: M_HREADY[m] = 1, M_HRESP[m] = 0.
- Data-phase tracking: on every HREADY=1 edge, downer <= aowner and dvalid <= HTRANS[1].
- Arbitration FSM, two states:
  - OWNED: owner driving NONSEQ/SEQ/BUSY.
  - SWITCHABLE: owner driving IDLE.
  - Re-arbitration happens only at a posedge with HREADY=1 while the owner drives IDLE.
  - At that edge, aowner <= first m with req[m], scanning aowner+1, aowner+2, … modulo NMASTER and wrapping to aowner itself last.
  - No requester: keep aowner (park).
  - Owner driving NONSEQ/SEQ/BUSY: never switch (burst and back-to-back integrity).
  - HREADY=0: no state change anywhere.
- Grant timing: a switch costs exactly one IDLE address phase (the old owner's). The new owner's held NONSEQ appears on the bus the cycle after the switch edge.
- Error response: the two-cycle ERROR passes through to the owner unchanged. The arbiter does not switch during it unless the owner drives IDLE in the second cycle.
- Simultaneous requests in the same cycle: the round-robin order decides. The loser stalls with no lost address.
- GRANT is registered and equals one-hot(aowner).

Optional Feature:
- AHB3LITE_ARB_FIXED_PRIO_EN defined: the scan always starts at index 0, so the lowest-index requester wins at each switch point. Parking is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, all masters IDLE -> GRANT=2'b01; all M_HREADY=1; HTRANS=IDLE; HADDR = M_HADDR[0].
- M1 issues NONSEQ to 0x10 while M0 idle -> M1 stalled one cycle; next cycle GRANT=2'b10, HADDR=0x10; M1 data phase completes with HWDATA from M1.
- M0 and M1 both stream 256 words of 32-bit writes to 0x000 (M0) and 0x400 (M1) -> each burst runs uninterrupted until its master drives IDLE. All 512 slave writes land at correct addresses/data; no duplicated or skipped address.
- Both request simultaneously at every switch point, with 3 transactions each -> grant order 1,0,1,0,1,0 from owner 0. With AHB3LITE_ARB_FIXED_PRIO_EN, master 0 wins every contested switch.
- Slave inserts 3 wait states (HREADY=0) during a switch window -> aowner/downer unchanged until HREADY=1; stalled master's address unchanged throughout.
- RESET asserted mid-burst by M1 -> next cycle GRANT=2'b01; downer=0; HTRANS shows M0's value.

Source files
------------

// File: rtl/ahb3lite_arb.sv
// ahb3lite_arb: N-master to single-slave AHB3-lite arbiter.
// Ownership changes only while the owner drives IDLE and HREADY is high,
// so no address phase is lost or repeated. Round-robin by default; define
// AHB3LITE_ARB_FIXED_PRIO_EN for lowest-index-first selection instead.
module ahb3lite_arb #(
   parameter int NMASTER       = 2,
   parameter int DEFAULT_OWNER = 0
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [NMASTER*32-1:0]  M_HADDR,
   input  logic [NMASTER*32-1:0]  M_HWDATA,
   input  logic [NMASTER-1:0]     M_HWRITE,
   input  logic [NMASTER*3-1:0]   M_HSIZE,
   input  logic [NMASTER*3-1:0]   M_HBURST,
   input  logic [NMASTER*4-1:0]   M_HPROT,
   input  logic [NMASTER*2-1:0]   M_HTRANS,
   output logic [31:0]            M_HRDATA,
   output logic [NMASTER-1:0]     M_HRESP,
   output logic [NMASTER-1:0]     M_HREADY,
   output logic [31:0]            HADDR,
   output logic [31:0]            HWDATA,
   output logic                   HWRITE,
   output logic [2:0]             HSIZE,
   output logic [2:0]             HBURST,
   output logic [3:0]             HPROT,
   output logic [1:0]             HTRANS,
   input  logic [31:0]            HRDATA,
   input  logic                   HRESP,
   input  logic                   HREADY,
   output logic [NMASTER-1:0]     GRANT
);

   localparam int AW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic {ST_OWNED, ST_SWITCHABLE} state_t;

   state_t             w_state;
   logic [AW-1:0]      r_aowner;
   logic [AW-1:0]      r_downer;
   logic               r_dvalid;
   logic [NMASTER-1:0] r_grant;
   logic [AW-1:0]      w_aowner_nxt;
   logic [NMASTER-1:0] w_grant_nxt;
   logic [AW-1:0]      w_idx;
   logic               w_found;
   logic [NMASTER-1:0] w_req;

   logic [31:0] w_haddr  [NMASTER];
   logic [31:0] w_hwdata [NMASTER];
   logic [2:0]  w_hsize  [NMASTER];
   logic [2:0]  w_hburst [NMASTER];
   logic [3:0]  w_hprot  [NMASTER];
   logic [1:0]  w_htrans [NMASTER];

   for (genvar g = 0; g < NMASTER; g++) begin : g_unpack
      assign w_haddr[g]  = M_HADDR[g*32 +: 32];
      assign w_hwdata[g] = M_HWDATA[g*32 +: 32];
      assign w_hsize[g]  = M_HSIZE[g*3 +: 3];
      assign w_hburst[g] = M_HBURST[g*3 +: 3];
      assign w_hprot[g]  = M_HPROT[g*4 +: 4];
      assign w_htrans[g] = M_HTRANS[g*2 +: 2];
      assign w_req[g]    = (M_HTRANS[g*2 +: 2] == HTRANS_NONSEQ);
   end

   // State register: owners, data-phase tracking and registered grant; all hold while HREADY is low
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_aowner <= AW'(DEFAULT_OWNER);
         r_downer <= AW'(DEFAULT_OWNER);
         r_dvalid <= 1'b0;
         r_grant  <= NMASTER'(1) << DEFAULT_OWNER;
      end else if (HREADY) begin
         r_aowner <= w_aowner_nxt;
         r_grant  <= w_grant_nxt;
         r_downer <= r_aowner;
         r_dvalid <= HTRANS[1];
      end
   end

   // Next state: classify the owner's phase and pick the next owner at a switch point
   always_comb begin
      w_state      = (HTRANS == HTRANS_IDLE) ? ST_SWITCHABLE : ST_OWNED;
      w_aowner_nxt = r_aowner;
      w_found      = 1'b0;
      w_idx        = '0;
      if (w_state == ST_SWITCHABLE && HREADY) begin
         for (int unsigned i = 0; i < NMASTER; i++) begin
`ifdef AHB3LITE_ARB_FIXED_PRIO_EN
            w_idx = AW'(i);
`else
            // scan starts just after the current owner and reaches it last
            w_idx = AW'((int'(r_aowner) + int'(i) + 1) % NMASTER);
`endif
            if (!w_found && w_req[w_idx]) begin
               w_aowner_nxt = w_idx;
               w_found      = 1'b1;
            end
         end
      end
      w_grant_nxt               = '0;
      w_grant_nxt[w_aowner_nxt] = 1'b1;
   end

   // Outputs: bus muxes by owner, per-master ready/response, stall non-owning requesters
   always_comb begin
      HADDR    = w_haddr[r_aowner];
      HWRITE   = M_HWRITE[r_aowner];
      HSIZE    = w_hsize[r_aowner];
      HBURST   = w_hburst[r_aowner];
      HPROT    = w_hprot[r_aowner];
      HTRANS   = w_htrans[r_aowner];
      HWDATA   = w_hwdata[r_downer];
      M_HRDATA = HRDATA;
      GRANT    = r_grant;
      M_HREADY = '1;
      M_HRESP  = '0;
      for (int unsigned m = 0; m < NMASTER; m++) begin
         if (AW'(m) == r_aowner) begin
            M_HREADY[m] = HREADY;
            M_HRESP[m]  = HRESP;
         end else if (w_req[m]) begin
            M_HREADY[m] = 1'b0;
         end
      end
   end

   // A live data phase always belongs to a real master
   a_downer_range: assert property (@(posedge CLK) disable iff (RESET)
      r_dvalid |-> (int'(r_downer) < NMASTER));

endmodule

// File: tb/tb_ahb3lite_arb.sv
// tb_ahb3lite_arb: vector table, streaming scoreboard and corner-case sequences.
`timescale 1ns/1ps
module tb_ahb3lite_arb;

   localparam int NW = 256;
   localparam logic [31:0] A0 = 32'h1000_0040, A1 = 32'h2000_0080;
   localparam logic [31:0] D0 = 32'hD0D0_0000, D1 = 32'hD1D1_1111;
   localparam logic [10:0] CTL0 = {1'b1, 3'b010, 3'b001, 4'b0011};
   localparam logic [10:0] CTL1 = {1'b0, 3'b001, 3'b011, 4'b1100};

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [63:0] m_haddr, m_hwdata;
   logic [1:0]  m_hwrite;
   logic [5:0]  m_hsize, m_hburst;
   logic [7:0]  m_hprot;
   logic [3:0]  m_htrans;
   logic [31:0] hrdata = '0;
   logic        hresp = 1'b0, hready = 1'b1;
   logic [31:0] m_hrdata, haddr, hwdata;
   logic [1:0]  m_hresp, m_hready, grant, htrans;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;

   // three-master instance for scan-order checks
   logic        rst3 = 1'b1;
   logic [95:0] m3_haddr = '0, m3_hwdata = '0;
   logic [2:0]  m3_hwrite = '0;
   logic [8:0]  m3_hsize = '0, m3_hburst = '0;
   logic [11:0] m3_hprot = '0;
   logic [5:0]  m3_htrans = '0;
   logic [31:0] o3_hrdata, o3_haddr, o3_hwdata;
   logic [2:0]  o3_hresp, o3_hready, grant3;
   logic        o3_hwrite;
   logic [2:0]  o3_hsize, o3_hburst;
   logic [3:0]  o3_hprot;
   logic [1:0]  o3_htrans;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   ahb3lite_arb #(.NMASTER(2), .DEFAULT_OWNER(0)) u_dut (
      .CLK(CLK), .RESET(RESET),
      .M_HADDR(m_haddr), .M_HWDATA(m_hwdata), .M_HWRITE(m_hwrite),
      .M_HSIZE(m_hsize), .M_HBURST(m_hburst), .M_HPROT(m_hprot), .M_HTRANS(m_htrans),
      .M_HRDATA(m_hrdata), .M_HRESP(m_hresp), .M_HREADY(m_hready),
      .HADDR(haddr), .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize),
      .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
      .HRDATA(hrdata), .HRESP(hresp), .HREADY(hready), .GRANT(grant)
   );

   ahb3lite_arb #(.NMASTER(3), .DEFAULT_OWNER(0)) u_dut3 (
      .CLK(CLK), .RESET(rst3),
      .M_HADDR(m3_haddr), .M_HWDATA(m3_hwdata), .M_HWRITE(m3_hwrite),
      .M_HSIZE(m3_hsize), .M_HBURST(m3_hburst), .M_HPROT(m3_hprot), .M_HTRANS(m3_htrans),
      .M_HRDATA(o3_hrdata), .M_HRESP(o3_hresp), .M_HREADY(o3_hready),
      .HADDR(o3_haddr), .HWDATA(o3_hwdata), .HWRITE(o3_hwrite), .HSIZE(o3_hsize),
      .HBURST(o3_hburst), .HPROT(o3_hprot), .HTRANS(o3_htrans),
      .HRDATA(32'h0), .HRESP(1'b0), .HREADY(1'b1), .GRANT(grant3)
   );

   typedef struct {
      logic [1:0] t0, t1;
      logic       rdy, resp;
      logic [1:0] grant, mrdy, mresp, htr;
      logic       hwsel;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   vec_t vecs [11];
   exp_t sb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   task automatic set_static();
      m_haddr  = {A1, A0};
      m_hwdata = {D1, D0};
      m_hwrite = 2'b01;
      m_hsize  = {3'b001, 3'b010};
      m_hburst = {3'b011, 3'b001};
      m_hprot  = {4'b1100, 4'b0011};
      m_htrans = '0;
      hresp    = 1'b0;
      hready   = 1'b1;
   endtask

   function automatic logic [31:0] sdata(input int m, input int i);
      return {8'hA5, 4'(m), 4'h0, 16'(i)};
   endfunction

   // stream master state
   int          w [2];
   bit          dp_v [2];
   int          dp_w [2];
   bit          s_dp_v;
   logic [31:0] s_dp_d;

   task automatic drive_stream();
      for (int m = 0; m < 2; m++) begin
         m_htrans[m*2 +: 2]  = (w[m] < NW) ? ((w[m] == 0) ? 2'b10 : 2'b11) : 2'b00;
         m_haddr[m*32 +: 32] = 32'(m * 32'h400) + 32'(w[m] * 4);
         m_hwdata[m*32 +: 32] = sdata(m, dp_w[m]);
      end
      m_hwrite = 2'b11;
      m_hburst = {3'b001, 3'b001};
      hready   = ($urandom_range(3) != 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] ctl;
      logic [31:0] exp_a;
      exp_t        e;
      int          nwr, nruns, last_rg;
      bit          done;

      vecs[0]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 1'b0};
      vecs[1]  = '{2'b00, 2'b10, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
      vecs[2]  = '{2'b00, 2'b10, 1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 2'b10, 1'b0};
      vecs[3]  = '{2'b10, 2'b11, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b11, 1'b1};
      vecs[4]  = '{2'b10, 2'b11, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b11, 1'b1};
      vecs[5]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1};
      vecs[6]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1};
      vecs[7]  = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1};
      vecs[8]  = '{2'b00, 2'b10, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
      vecs[9]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0};
      vecs[10] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b01, 2'b10, 2'b00, 1'b1};

      // ---------------- table-driven vectors from reset ----------------
      set_static();
      reset_dut();
      for (int i = 0; i < 11; i++) begin
         if (i > 0) step();
         m_htrans = {vecs[i].t1, vecs[i].t0};
         hready   = vecs[i].rdy;
         hresp    = vecs[i].resp;
         hrdata   = $urandom;
         @(negedge CLK);
         exp_a = vecs[i].grant[1] ? A1 : A0;
         ctl   = vecs[i].grant[1] ? CTL1 : CTL0;
         chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
         chk($sformatf("v%0d_mhready", i), 32'(m_hready), 32'(vecs[i].mrdy));
         chk($sformatf("v%0d_mhresp", i), 32'(m_hresp), 32'(vecs[i].mresp));
         chk($sformatf("v%0d_htrans", i), 32'(htrans), 32'(vecs[i].htr));
         chk($sformatf("v%0d_haddr", i), haddr, exp_a);
         chk($sformatf("v%0d_ctl", i), 32'({hwrite, hsize, hburst, hprot}), 32'(ctl));
         chk($sformatf("v%0d_hwdata", i), hwdata, vecs[i].hwsel ? D1 : D0);
         chk($sformatf("v%0d_hrdata", i), m_hrdata, hrdata);
      end

      // ---------------- three-master scan order ----------------
      step();
      rst3 = 1'b0;
      m3_htrans = {2'b10, 2'b10, 2'b00};
      @(negedge CLK);
      chk("rr3_reset_grant", 32'(grant3), 32'b001);
      step();
      m3_htrans = {2'b10, 2'b00, 2'b10};
      @(negedge CLK);
      chk("rr3_grant_a", 32'(grant3), 32'b010);
      step();
      m3_htrans = {2'b00, 2'b10, 2'b10};
      @(negedge CLK);
`ifdef AHB3LITE_ARB_FIXED_PRIO_EN
      chk("rr3_grant_b", 32'(grant3), 32'b001);
`else
      chk("rr3_grant_b", 32'(grant3), 32'b100);
`endif
      step();
      @(negedge CLK);
      chk("rr3_grant_c", 32'(grant3), 32'b001);

      // ---------------- streaming writes with scoreboard ----------------
      w = '{0, 0};
      dp_v = '{0, 0};
      dp_w = '{0, 0};
      s_dp_v = 1'b0;
      sb.delete();
      nwr = 0;
      nruns = 0;
      last_rg = -1;
      done = 1'b0;
      reset_dut();
      drive_stream();
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         @(negedge CLK);
         if (hready && s_dp_v) begin
            chk("stream_wdata", hwdata, s_dp_d);
            s_dp_v = 1'b0;
         end
         for (int m = 0; m < 2; m++) begin
            if (m_hready[m]) begin
               dp_v[m] = 1'b0;
               if (m_htrans[m*2+1]) begin
                  sb.push_back('{32'(m * 32'h400) + 32'(w[m] * 4), sdata(m, w[m])});
                  dp_v[m] = 1'b1;
                  dp_w[m] = w[m];
                  w[m]++;
               end
            end
         end
         if (hready && htrans[1]) begin
            if (sb.size() == 0) begin
               chk("stream_unexpected_addr", haddr, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("stream_waddr", haddr, e.a);
               s_dp_v = 1'b1;
               s_dp_d = e.d;
               nwr++;
               if (int'(haddr[10]) != last_rg) nruns++;
               last_rg = int'(haddr[10]);
            end
         end
         done = (w[0] == NW) && (w[1] == NW) && !dp_v[0] && !dp_v[1] && !s_dp_v;
         step();
         drive_stream();
      end
      chk("stream_done", 32'(done), 32'd1);
      chk("stream_nwrites", 32'(nwr), 32'd512);
      chk("stream_owner_runs", 32'(nruns), 32'd2);
      chk("stream_sb_left", 32'(sb.size()), 32'd0);

      // ---------------- reset in the middle of an M1 burst ----------------
      set_static();
      reset_dut();
      m_htrans = {2'b10, 2'b00};
      step();
      m_htrans = {2'b11, 2'b10};
      @(negedge CLK);
      chk("pre_rst_hwdata_a", hwdata, D0);
      step();
      @(negedge CLK);
      chk("pre_rst_grant", 32'(grant), 32'b10);
      chk("pre_rst_hwdata_b", hwdata, D1);
      step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_grant", 32'(grant), 32'b01);
      chk("rst_htrans", 32'(htrans), 32'b10);
      chk("rst_haddr", haddr, A0);
      chk("rst_hwdata", hwdata, D0);

      // ---------------- wait states inside a switch window ----------------
      set_static();
      reset_dut();
      m_htrans = {2'b10, 2'b00};
      step();
      step();
      m_htrans = {2'b00, 2'b10};
      hready   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk($sformatf("ws%0d_grant", k), 32'(grant), 32'b10);
         chk($sformatf("ws%0d_m0_stall", k), 32'(m_hready), 32'b00);
         chk($sformatf("ws%0d_haddr", k), haddr, A1);
         chk($sformatf("ws%0d_hwdata", k), hwdata, D1);
         step();
      end
      hready = 1'b1;
      @(negedge CLK);
      chk("ws_release_grant", 32'(grant), 32'b10);
      chk("ws_release_mready", 32'(m_hready), 32'b10);
      step();
      @(negedge CLK);
      chk("ws_switched_grant", 32'(grant), 32'b01);
      chk("ws_switched_haddr", haddr, A0);
      chk("ws_switched_htrans", 32'(htrans), 32'b10);
      chk("ws_switched_mready", 32'(m_hready), 32'b11);
      chk("ws_switched_hwdata", hwdata, D1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
